// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-driven ALU controller: FSM state encoding and ALU opcodes.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

  function automatic logic is_busy_state(input state_t s);
    return (s == ST_SEND) || (s == ST_WAIT_TX);
  endfunction

endpackage

// File: rtl/uart_alu_timeout.sv
// Inter-byte timeout: down-counter reloaded by clear, decremented while enabled,
// one-cycle expired pulse on the last enabled cycle of the window.
module uart_alu_timeout #(
  parameter int CYCLES = 100000
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Terminal count reached while still waiting: the window of CYCLES idle cycles is complete.
  assign expired = enable && (count == '0);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B and opcode bytes from a UART receiver, drives an external ALU and sends the result.
// Optional inter-byte timeout enabled by defining UART_ALU_CTRL_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | waiting for operand A byte
// WAIT_B     | A latched, waiting for operand B byte
// WAIT_OP    | B latched, waiting for opcode byte
// SEND       | one cycle: capture ALU result, pulse tx start
// WAIT_TX    | result held, waiting for transmitter done
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int NB_OP          = 6,
  parameter int NB_DATA        = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_A,
  output logic [NB_DATA-1:0] o_alu_B,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy,
  output logic               o_overrun
);

  state_t state;
  logic   timeout_hit;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic tmo_clear;
  logic tmo_enable;

  assign tmo_clear  = i_rx_valid && ((state == ST_IDLE) || (state == ST_WAIT_B));
  assign tmo_enable = !i_rx_valid && ((state == ST_WAIT_B) || (state == ST_WAIT_OP));

  uart_alu_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_sys (i_clk),
    .rst     (i_reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      o_alu_A    <= '0;
      o_alu_B    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_overrun  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            o_alu_A <= i_rx_data;
            state   <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (i_rx_valid) begin
            o_alu_B <= i_rx_data;
            state   <= ST_WAIT_OP;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_OP: begin
          if (i_rx_valid) begin
            o_alu_op   <= i_rx_data[NB_OP-1:0];
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
            state      <= ST_SEND;
          end else if (timeout_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          // Operands settled at the previous edge, so the ALU output is valid here.
          o_tx_data <= i_alu_result;
          o_overrun <= i_rx_valid;
          state     <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          o_overrun <= i_rx_valid;
          if (i_tx_done) begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl with a behavioural ALU attached and a reference result model.
module tb_uart_alu_ctrl;
  import uart_alu_pkg::*;

  localparam int NB_OP   = 6;
  localparam int NB_DATA = 8;
  localparam int TMO     = 16;

  logic               clk;
  logic               rst;
  logic [NB_DATA-1:0] rx_data;
  logic               rx_valid;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               tx_done;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] alu_result;
  logic               busy;
  logic               overrun;

  int total = 0;
  int bad   = 0;

  uart_alu_ctrl #(
    .NB_OP          (NB_OP),
    .NB_DATA        (NB_DATA),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_done    (tx_done),
    .o_alu_A      (alu_a),
    .o_alu_B      (alu_b),
    .o_alu_op     (alu_op),
    .i_alu_result (alu_result),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU the controller drives.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD: alu_result = alu_a + alu_b;
      OP_SUB: alu_result = alu_a - alu_b;
      OP_AND: alu_result = alu_a & alu_b;
      OP_OR:  alu_result = alu_a | alu_b;
      OP_XOR: alu_result = alu_a ^ alu_b;
      OP_SRA: alu_result = NB_DATA'($signed(alu_a) >>> alu_b);
      OP_SRL: alu_result = alu_a >> alu_b;
      OP_NOR: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end

  // Reference: expected transmitted byte from the three received bytes, integer arithmetic.
  function automatic int model(input int a, input int b, input int opb);
    int op;
    int sa;
    int sh;
    op = opb % 64;
    sa = (a > 127) ? a - 256 : a;
    sh = (b > 7) ? 8 : b;
    case (op)
      32: return (a + b) % 256;
      34: return (a - b + 256) % 256;
      36: return a & b;
      37: return a | b;
      38: return a ^ b;
      39: return 255 - (a | b);
      2:  return (sh == 8) ? 0 : (a / (1 << sh));
      3:  begin
            if (sh == 8) return (sa < 0) ? 255 : 0;
            return (sa >>> sh) & 255;
          end
      default: return 0;
    endcase
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int b);
    rx_data  = NB_DATA'(b);
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic do_txn(input string tag, input int a, input int b, input int opb);
    int exp;
    exp = model(a, b, opb);
    send(a);
    check({tag, ".A"}, int'(alu_a), a);
    check({tag, ".busy_a"}, int'(busy), 0);
    send(b);
    check({tag, ".B"}, int'(alu_b), b);
    send(opb);
    check({tag, ".op"}, int'(alu_op), opb % 64);
    check({tag, ".start"}, int'(tx_start), 1);
    check({tag, ".busy_send"}, int'(busy), 1);
    @(negedge clk);
    check({tag, ".start_off"}, int'(tx_start), 0);
    check({tag, ".result"}, int'(tx_data), exp);
    check({tag, ".busy_tx"}, int'(busy), 1);
    pulse_done();
    check({tag, ".busy_done"}, int'(busy), 0);
    check({tag, ".hold"}, int'(tx_data), exp);
    check({tag, ".ovr"}, int'(overrun), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".A"}, int'(alu_a), 0);
    check({tag, ".B"}, int'(alu_b), 0);
    check({tag, ".op"}, int'(alu_op), 0);
    check({tag, ".tx_data"}, int'(tx_data), 0);
    check({tag, ".start"}, int'(tx_start), 0);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".ovr"}, int'(overrun), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ops [8] = '{32, 34, 36, 37, 38, 3, 2, 39};
    int a, b, opb;

    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_done = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    do_txn("add", 8'h05, 8'h03, 8'h20);
    do_txn("sub", 8'h03, 8'h05, 8'h22);
    do_txn("sra", 8'h80, 8'h02, 8'h03);
    do_txn("srl", 8'h80, 8'h02, 8'h02);
    do_txn("add_hi", 8'h01, 8'h01, 8'hE0);
    do_txn("undef", 8'h12, 8'h34, 8'h3F);
    do_txn("nor", 8'h0F, 8'h30, 8'h27);

    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 255));
      b = (i % 3 == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
      if (i % 6 == 5) opb = int'($urandom_range(0, 255));
      else opb = ops[$urandom_range(0, 7)] + 64 * int'($urandom_range(0, 3));
      do_txn("rand", a, b, opb);
    end

    // Stray tx_done in IDLE and WAIT_B must not disturb collection.
    pulse_done();
    send(8'h0C);
    pulse_done();
    check("done_ign.busy", int'(busy), 0);
    send(8'h0A);
    send(8'h26);
    check("done_ign.start", int'(tx_start), 1);
    @(negedge clk);
    check("done_ign.result", int'(tx_data), model(8'h0C, 8'h0A, 8'h26));
    pulse_done();

    // Bytes dropped in SEND, in WAIT_TX, and together with tx_done.
    send(8'h05); send(8'h03); send(8'h20);
    send(8'hAA);
    check("ovr_send.pulse", int'(overrun), 1);
    check("ovr_send.A", int'(alu_a), 8'h05);
    check("ovr_send.result", int'(tx_data), 8'h08);
    @(negedge clk);
    check("ovr_send.once", int'(overrun), 0);
    send(8'hBB);
    check("ovr_tx.pulse", int'(overrun), 1);
    check("ovr_tx.busy", int'(busy), 1);
    check("ovr_tx.B", int'(alu_b), 8'h03);
    rx_data = 8'h77; rx_valid = 1'b1; tx_done = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; tx_done = 1'b0;
    check("ovr_done.pulse", int'(overrun), 1);
    check("ovr_done.busy", int'(busy), 0);
    check("ovr_done.A", int'(alu_a), 8'h05);
    @(negedge clk);
    check("ovr_done.once", int'(overrun), 0);
    do_txn("after_ovr", 8'h03, 8'h05, 8'h22);

    // Asynchronous reset in WAIT_OP, checked before any clock edge.
    send(8'h11); send(8'h22);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_waitop");
    @(negedge clk);
    rst = 1'b0;
    do_txn("after_rst", 8'h07, 8'h01, 8'h24);

    // Reset in WAIT_TX clears the held result.
    send(8'h40); send(8'h01); send(8'h20);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_waittx");
    @(negedge clk);
    rst = 1'b0;
    do_txn("after_rst2", 8'h09, 8'h06, 8'h26);

    // Gaps shorter than the timeout, restarted by each accepted byte.
    send(8'h21);
    repeat (TMO - 6) @(negedge clk);
    send(8'h13);
    repeat (TMO - 6) @(negedge clk);
    send(8'h20);
    check("gap.start", int'(tx_start), 1);
    @(negedge clk);
    check("gap.result", int'(tx_data), 8'h34);
    pulse_done();

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    // One idle cycle short of the timeout still accepts B.
    send(8'h30);
    repeat (TMO - 1) @(negedge clk);
    send(8'h04);
    check("tmo_edge.B", int'(alu_b), 8'h04);
    pulse_done();
    repeat (TMO) @(negedge clk);
    // Back in IDLE, operands kept.
    check("tmo_op.A_kept", int'(alu_a), 8'h30);
    check("tmo_op.busy", int'(busy), 0);
    send(8'h09);
    repeat (TMO) @(negedge clk);
    check("tmo.A_kept", int'(alu_a), 8'h09);
    do_txn("tmo_after", 8'h02, 8'h02, 8'h20);
`else
    send(8'h09);
    repeat (TMO) @(negedge clk);
    send(8'h02);
    check("no_tmo.A", int'(alu_a), 8'h09);
    check("no_tmo.B", int'(alu_b), 8'h02);
    send(8'h20);
    check("no_tmo.start", int'(tx_start), 1);
    @(negedge clk);
    check("no_tmo.result", int'(tx_data), model(8'h09, 8'h02, 8'h20));
    pulse_done();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 SHALL have parameter NB_OP, default 6, meaning ALU opcode width.
REQ-002 SHALL have parameter NB_DATA, default 8, meaning operand, result and serial byte width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning inter-byte timeout length in clock cycles.
REQ-004 SHALL have one clock and one reset: i_clk input 1, the single clock; reset is asynchronous and active-high.
REQ-005 SHALL have port i_reset input 1, asynchronous active-high reset.
REQ-006 SHALL have port i_rx_data input NB_DATA, received byte, valid only with i_rx_valid.
REQ-007 SHALL have port i_rx_valid input 1, one-cycle pulse marking a received byte.
REQ-008 SHALL have port o_tx_data output NB_DATA, byte to transmit.
REQ-009 SHALL have port o_tx_start output 1, one-cycle transmit request pulse.
REQ-010 SHALL have port i_tx_done input 1, one-cycle pulse when the transmitter finishes.
REQ-011 SHALL have ports o_alu_A and o_alu_B, output NB_DATA each, registered ALU operands.
REQ-012 SHALL have port o_alu_op output NB_OP, registered ALU opcode.
REQ-013 SHALL have port i_alu_result input NB_DATA, combinational ALU result.
REQ-014 SHALL have port o_busy output 1, high while a result is pending or in transmission.
REQ-015 SHALL have port o_overrun output 1, one-cycle pulse when a received byte is dropped.

Function
REQ-016 SHALL implement the states IDLE, WAIT_B, WAIT_OP, SEND and WAIT_TX.
REQ-017 IDLE: an i_rx_valid pulse latches i_rx_data into o_alu_A and moves the FSM to WAIT_B.
REQ-018 WAIT_B: an i_rx_valid pulse latches the byte into o_alu_B and moves the FSM to WAIT_OP.
REQ-019 WAIT_OP: an i_rx_valid pulse latches i_rx_data[NB_OP-1:0] into o_alu_op, ignores the upper bits, and moves the FSM to SEND.
REQ-020 SEND lasts exactly one cycle: it captures i_alu_result into o_tx_data, asserts o_tx_start for that cycle, and moves the FSM to WAIT_TX.
REQ-021 Latency SHALL be one cycle from the op byte's i_rx_valid to o_tx_start.
REQ-022 WAIT_TX: i_tx_done moves the FSM to IDLE, and o_tx_data holds its value until the next SEND.
REQ-023 o_busy SHALL be high exactly in SEND and WAIT_TX.
REQ-024 An i_rx_valid pulse in SEND or WAIT_TX drops the byte, pulses o_overrun the following cycle, and leaves state and registers unchanged.
REQ-025 If i_rx_valid and i_tx_done coincide in WAIT_TX, the FSM goes to IDLE and the byte is dropped with o_overrun.
REQ-026 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-027 Operands and opcode SHALL remain stable from capture through WAIT_TX, so the ALU result is static during transmission.
REQ-028 Unreachable state encodings SHALL return the FSM to IDLE on the next clock.

Reset
REQ-029 i_reset SHALL asynchronously force the FSM to IDLE and clear o_alu_A, o_alu_B, o_alu_op, o_tx_data, o_tx_start, o_busy, o_overrun and the timeout counter to 0.
REQ-030 Reset mid-operation (any state) SHALL discard partial operands; the first byte after reset release is treated as A.

Configuration
REQ-031 Macro UART_ALU_CTRL_TIMEOUT_EN defined: in WAIT_B or WAIT_OP, if TIMEOUT_CYCLES consecutive cycles pass without i_rx_valid, the FSM returns to IDLE; operand registers are kept, and the counter restarts on every accepted byte.
REQ-032 Macro undefined: no timeout logic exists, and WAIT_B/WAIT_OP wait indefinitely.

Structure
REQ-033 Package uart_alu_pkg SHALL hold the FSM state encoding and the ALU opcode constants (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111), shared with the ALU and benches.
REQ-034 The timeout counter SHALL be the single sub-module uart_alu_timeout (clear, enable, expired pulse), instantiated only under UART_ALU_CTRL_TIMEOUT_EN.
REQ-035 The ALU SHALL be instantiated outside this block and connected through the o_alu_* and i_alu_result ports.

Verification
REQ-036 Bytes 0x05, 0x03, 0x20 with the ALU connected -> o_tx_start one cycle after the third pulse, o_tx_data=0x08.
REQ-037 Bytes 0x03, 0x05, 0x22 -> o_tx_data=0xFE; bytes 0x80, 0x02, 0x03 -> 0xE0; bytes 0x80, 0x02, 0x02 -> 0x20.
REQ-038 Op byte 0xE0 (low bits 100000, ADD) with A=0x01, B=0x01 -> 0x02; op byte 0x3F (undefined) -> 0x00.
REQ-039 A byte sent during WAIT_TX, including one in the same cycle as i_tx_done -> o_overrun pulses once, the FSM reaches IDLE, and the next three bytes form a correct transaction.
REQ-040 i_reset asserted in WAIT_OP -> all outputs 0 immediately; then bytes 0x07, 0x01, 0x24 -> 0x01.
REQ-041 With UART_ALU_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, one byte then 16 idle cycles -> IDLE; then 0x02, 0x02, 0x20 -> 0x04; without the macro the FSM stays in WAIT_B.
